line_mem_ctrl: RTL and testbench
================================

Name: line_mem_ctrl

Overview:
Main-memory line controller directly downstream of the 2-way data cache. Serves cache-line fills and dirty-line writebacks over the cache's miss bus (addr_mem, data_to_mem, wrt_bck, mem_rdy, data_from_mem). Holds a line-granular backing store with programmable read and write latency. Includes a preload port for boot and bench initialisation.

Parameters:
ADDR_W, 14, line address width ({tag,index} from the cache)
DATA_W, 64, line width in bits
DEPTH_LOG2, 10, backing store depth = 2**DEPTH_LOG2 lines; the low DEPTH_LOG2 address bits index it
RD_LAT, 4, fill latency in cycles, legal range 1..15
WR_LAT, 4, writeback commit latency in cycles, legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  fill request = cache enable & ~miss_hit
addr_mem  in  ADDR_W  line address from the cache; holds the victim address in the cycle after mem_rdy when a writeback occurs
data_to_mem  in  DATA_W  victim line from the cache, valid in the cycle after mem_rdy
wrt_bck  in  1  cache's writeback-needed flag, sampled in the mem_rdy cycle
ld_en  in  1  preload write strobe
ld_addr  in  ADDR_W  preload line address
ld_data  in  DATA_W  preload line data
mem_rdy  out  1  one-cycle fill strobe to the cache
data_from_mem  out  DATA_W  fill line, valid while mem_rdy=1
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; mem_rdy=0, data_from_mem=0, busy=0; latency counter 0; pending writeback cleared. Store contents are not cleared. Reset mid-operation aborts any fill or writeback, and nothing is written.
- All outputs are registered.
- States: IDLE, RD_WAIT, RESP, WB_CAP, WB_WAIT.
- IDLE:
  - ld_en=1: write ld_data to store[ld_addr low bits] this edge. Preload has priority over req.
  - Otherwise, req=1: latch addr_mem, load counter with RD_LAT-1, go to RD_WAIT.
  - ld_en is ignored in all other states.
- RD_WAIT: decrement the counter each edge. At counter 0, register data_from_mem <= store[latched addr] and mem_rdy <= 1, then go to RESP.
  - Total latency: req sampled at edge N gives mem_rdy high in the cycle after edge N+RD_LAT.
- RESP (mem_rdy=1, exactly one cycle):
  - Sample wrt_bck.
  - wrt_bck=1: go to WB_CAP.
  - wrt_bck=0: go to IDLE.
  - Drop mem_rdy at the exit edge. data_from_mem holds its value until the next fill.
- WB_CAP: the cache's registered victim address and data are now on addr_mem/data_to_mem. Capture both at this edge, load the counter with WR_LAT-1, go to WB_WAIT.
  - A new cache miss that rewrites addr_mem at the same edge does not corrupt the capture, because the capture samples pre-edge values.
- WB_WAIT: decrement the counter. At 0, write the captured data to store[captured addr], go to IDLE.
- A req held high during busy is not lost. It is serviced on the first IDLE cycle after the current transaction completes.
- req deasserting during RD_WAIT does not cancel the fill. The fill completes and mem_rdy still pulses.
- Writeback followed by a fill of the same address: the write commits in WB_WAIT before IDLE re-arms, so the fill returns the written-back data.
- Addresses wider than the store alias modulo 2**DEPTH_LOG2.

Optional Feature:
LINE_MEM_CTRL_STATS_EN
- Defined: adds outputs fill_cnt[15:0] and wb_cnt[15:0].
  - fill_cnt increments on each RESP cycle.
  - wb_cnt increments on each store write in WB_WAIT.
  - Both wrap at 16'hFFFF -> 0. Both reset to 0 on rst; preload writes are not counted.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package line_mem_pkg: state enum (IDLE, RD_WAIT, RESP, WB_CAP, WB_WAIT); LINE_ADDR_W=14, LINE_DATA_W=64, LAT_W=4.
- One sub-module, line_store: single-port array of 2**DEPTH_LOG2 x DATA_W with synchronous write and combinational read. The controller registers the read output.

Test Plan:
- Reset then idle: rst pulse mid-RD_WAIT -> mem_rdy=0 and busy=0 immediately (async); no store write; next req fills normally.
- Clean fill: preload 14'h0012=64'hDEAD_BEEF_0123_4567, req at edge 0 with addr_mem=14'h0012, wrt_bck=0 -> mem_rdy high only in the cycle after edge 4 with that data, then IDLE.
- Fill plus writeback: fill 14'h0040 with wrt_bck=1; in the next cycle drive addr_mem=14'h0013, data_to_mem=64'hAAAA_5555_AAAA_5555 -> after WR_LAT, store[0x13] holds that value; a subsequent fill of 0x13 returns it.
- Back-to-back: req held high through a fill with writeback -> the second mem_rdy arrives exactly RD_LAT+1 edges after WB_WAIT exits; no request is dropped.
- Preload vs request: ld_en=1 and req=1 together in IDLE -> preload written, fill starts the next edge; ld_en during busy -> no write.
- Aliasing/stats (LINE_MEM_CTRL_STATS_EN): fill 14'h0400 with DEPTH_LOG2=10 -> returns store[0]; after 3 fills and 1 writeback, fill_cnt=3 and wb_cnt=1.

Source files
------------

// File: rtl/line_mem_pkg.sv
// Purpose: shared types and constants for the main-memory line controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package line_mem_pkg;

    localparam int LINE_ADDR_W = 14;
    localparam int LINE_DATA_W = 64;
    localparam int LAT_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RESP,
        WB_CAP,
        WB_WAIT
    } state_e;

    // The counter is loaded with lat-1 so that a latency of L spends exactly
    // L edges between the accepting edge and the completing edge.
    function automatic logic [LAT_W-1:0] lat_load(input int lat);
        return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/line_store.sv
// Purpose: line-granular backing store, single port, synchronous write,
//          combinational read.
// Latency: write commits at the clock edge; read data follows addr_i in the same cycle.
// Backpressure: none; one access per cycle, the owner arbitrates.
// Ports: clk; we_i/addr_i/wdata_i write port; rdata_o reads addr_i.
module line_store
    import line_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = LINE_DATA_W
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    // Contents are deliberately not reset: boot code preloads them.
    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_mem_ctrl.sv
// Purpose: main-memory line controller behind the 2-way data cache; serves
//          line fills and dirty-line writebacks, plus a boot preload port.
// Latency: fill strobe RD_LAT cycles after req is accepted; writeback commits
//          WR_LAT cycles after the victim is captured.
// Backpressure: busy is high outside IDLE; a held req waits and is served on
//          the first IDLE cycle; ld_en outside IDLE is ignored.
// Ports: clk, rst (async, active high); req/addr_mem/wrt_bck/data_to_mem
//        from the cache; ld_en/ld_addr/ld_data preload; mem_rdy,
//        data_from_mem, busy to the cache.
// Optional: LINE_MEM_CTRL_STATS_EN adds fill_cnt/wb_cnt event counters.
module line_mem_ctrl
    import line_mem_pkg::*;
#(
    parameter int ADDR_W     = LINE_ADDR_W,
    parameter int DATA_W     = LINE_DATA_W,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 4,
    parameter int WR_LAT     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] data_to_mem,
    input  logic              wrt_bck,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              mem_rdy,
    output logic [DATA_W-1:0] data_from_mem,
    output logic              busy
`ifdef LINE_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]       fill_cnt,
    output logic [15:0]       wb_cnt
`endif
);

    localparam logic [LAT_W-1:0] RD_LOAD = lat_load(RD_LAT);
    localparam logic [LAT_W-1:0] WR_LOAD = lat_load(WR_LAT);

    state_e                  state_q,   state_d;
    logic [LAT_W-1:0]        cnt_q,     cnt_d;
    logic [DEPTH_LOG2-1:0]   rd_idx_q,  rd_idx_d;
    logic [DEPTH_LOG2-1:0]   wb_idx_q,  wb_idx_d;
    logic [DATA_W-1:0]       wb_data_q, wb_data_d;
    logic [DATA_W-1:0]       rdata_q,   rdata_d;
    logic                    rdy_q,     rdy_d;
    logic                    busy_q,    busy_d;

    logic                    st_we;
    logic [DEPTH_LOG2-1:0]   st_addr;
    logic [DATA_W-1:0]       st_wdata;
    logic [DATA_W-1:0]       st_rdata;

    // Upper address bits only select beyond the store; they alias away.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr_mem[ADDR_W-1:DEPTH_LOG2], ld_addr[ADDR_W-1:DEPTH_LOG2]};

    line_store #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_store (
        .clk     (clk),
        .we_i    (st_we),
        .addr_i  (st_addr),
        .wdata_i (st_wdata),
        .rdata_o (st_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_idx_d  = rd_idx_q;
        wb_idx_d  = wb_idx_q;
        wb_data_d = wb_data_q;
        rdata_d   = rdata_q;
        rdy_d     = 1'b0;
        st_we     = 1'b0;
        st_addr   = rd_idx_q;
        st_wdata  = wb_data_q;

        // The single store port is never contended: preload only in IDLE,
        // reads only in RD_WAIT, writeback commits only in WB_WAIT.
        unique case (state_q)
            IDLE: begin
                if (ld_en) begin
                    st_we    = 1'b1;
                    st_addr  = ld_addr[DEPTH_LOG2-1:0];
                    st_wdata = ld_data;
                end else if (req) begin
                    rd_idx_d = addr_mem[DEPTH_LOG2-1:0];
                    cnt_d    = RD_LOAD;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                st_addr = rd_idx_q;
                if (cnt_q == '0) begin
                    rdata_d = st_rdata;
                    rdy_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                state_d = wrt_bck ? WB_CAP : IDLE;
            end
            WB_CAP: begin
                // Cache presents its registered victim this cycle; sampling
                // pre-edge values keeps a same-edge new miss from corrupting it.
                wb_idx_d  = addr_mem[DEPTH_LOG2-1:0];
                wb_data_d = data_to_mem;
                cnt_d     = WR_LOAD;
                state_d   = WB_WAIT;
            end
            WB_WAIT: begin
                st_addr = wb_idx_q;
                if (cnt_q == '0) begin
                    st_we   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Suppress writes while reset is held so an aborted op leaves no trace.
        if (rst) begin
            st_we = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_idx_q  <= '0;
            wb_idx_q  <= '0;
            wb_data_q <= '0;
            rdata_q   <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            wb_idx_q  <= wb_idx_d;
            wb_data_q <= wb_data_d;
            rdata_q   <= rdata_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_rdy       = rdy_q;
    assign data_from_mem = rdata_q;
    assign busy          = busy_q;

`ifdef LINE_MEM_CTRL_STATS_EN
    logic [15:0] fill_cnt_q, fill_cnt_d;
    logic [15:0] wb_cnt_q,   wb_cnt_d;

    // Both counters wrap naturally at 16 bits; preloads are not counted.
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (state_q == RESP) begin
            fill_cnt_d = fill_cnt_q + 16'd1;
        end
        if (state_q == WB_WAIT && cnt_q == '0) begin
            wb_cnt_d = wb_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign fill_cnt = fill_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Purpose: self-checking bench for line_mem_ctrl; directed fills, writebacks,
//          resets and preloads with a cycle-accurate expected-fill scoreboard.
// Latency/backpressure: n/a (bench).
module tb_line_mem_ctrl;

    localparam int RD = 4;
    localparam int WR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [13:0] addr_mem = '0;
    logic [63:0] data_to_mem = '0;
    logic        wrt_bck = 1'b0;
    logic        ld_en = 1'b0;
    logic [13:0] ld_addr = '0;
    logic [63:0] ld_data = '0;
    logic        mem_rdy;
    logic [63:0] data_from_mem;
    logic        busy;
`ifdef LINE_MEM_CTRL_STATS_EN
    logic [15:0] fill_cnt;
    logic [15:0] wb_cnt;
`endif

    line_mem_ctrl #(
        .ADDR_W(14), .DATA_W(64), .DEPTH_LOG2(10), .RD_LAT(RD), .WR_LAT(WR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .addr_mem      (addr_mem),
        .data_to_mem   (data_to_mem),
        .wrt_bck       (wrt_bck),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .mem_rdy       (mem_rdy),
        .data_from_mem (data_from_mem),
        .busy          (busy)
`ifdef LINE_MEM_CTRL_STATS_EN
        ,
        .fill_cnt      (fill_cnt),
        .wb_cnt        (wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] d;
        int          c;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int n_fill = 0;
    int n_wb   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every mem_rdy cycle must match the head of the scoreboard in
    // both data and the edge after which it appeared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && mem_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mem_rdy cycle=%0d data=%h", cyc, data_from_mem);
                end else begin
                    e = sb.pop_front();
                    if (data_from_mem !== e.d || cyc != e.c) begin
                        errors++;
                        $display("FAIL fill actual data=%h cycle=%0d required data=%h cycle=%0d",
                                 data_from_mem, cyc, e.d, e.c);
                    end
                end
            end
        end
    end

    // Advance to 1 time unit after edge number c.
    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [13:0] a, input logic [63:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick_to(cyc + 1);
        ld_en = 1'b0;
    endtask

    task automatic fill(input logic [13:0] a, input logic [63:0] exp, input logic wb,
                        input logic [13:0] va, input logic [63:0] vd);
        int k;
        k = cyc;
        req = 1'b1; addr_mem = a; wrt_bck = wb;
        sb.push_back('{exp, k + 1 + RD});
        n_fill++;
        tick_to(k + 1);
        req = 1'b0;                       // dropping req mid-fill must not cancel it
        tick_to(k + 2 + RD);
        wrt_bck = 1'b0;
        if (wb) begin
            addr_mem = va; data_to_mem = vd;
            tick_to(k + 3 + RD);
            addr_mem = '0; data_to_mem = '0;
            tick_to(k + 3 + RD + WR);
            n_wb++;
        end
        chk("busy_after_fill", {63'd0, busy}, 64'd0);
        chk("data_hold", data_from_mem, exp);
    endtask

    initial begin
        int k;
        // Reset state.
        tick_to(2);
        chk("rst_mem_rdy", {63'd0, mem_rdy}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_data", data_from_mem, 64'd0);
        rst = 1'b0;

        // Preload the lines used below.
        preload(14'h0012, 64'hDEAD_BEEF_0123_4567);
        preload(14'h0030, 64'h3030_3030_0000_0001);
        preload(14'h0031, 64'h3131_3131_0000_0002);
        preload(14'h0032, 64'h3232_3232_0000_0003);
        preload(14'h0040, 64'h4040_4040_0000_0004);
        preload(14'h0041, 64'h4141_4141_0000_0005);
        preload(14'h0051, 64'h5151_5151_0000_0006);
        preload(14'h0000, 64'h0F0F_0F0F_0000_0007);

        // Clean fill.
        fill(14'h0012, 64'hDEAD_BEEF_0123_4567, 1'b0, '0, '0);

        // Reset mid-RD_WAIT: async clear, no response, next fill normal.
        k = cyc;
        req = 1'b1; addr_mem = 14'h0030;
        tick_to(k + 1);
        req = 1'b0;
        tick_to(k + 3);
        chk("busy_in_rd_wait", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_mem_rdy", {63'd0, mem_rdy}, 64'd0);
        chk("async_rst_data", data_from_mem, 64'd0);
        tick_to(k + 5);
        rst = 1'b0;
        n_fill = 0; n_wb = 0;
        fill(14'h0030, 64'h3030_3030_0000_0001, 1'b0, '0, '0);

        // Reset mid-WB_WAIT: victim write to 0x32 must be abandoned.
        k = cyc;
        req = 1'b1; addr_mem = 14'h0031; wrt_bck = 1'b1;
        sb.push_back('{64'h3131_3131_0000_0002, k + 1 + RD});
        tick_to(k + 1);
        req = 1'b0;
        tick_to(k + 2 + RD);
        wrt_bck = 1'b0; addr_mem = 14'h0032; data_to_mem = 64'hBAD0_BAD0_BAD0_BAD0;
        tick_to(k + 3 + RD);
        addr_mem = '0; data_to_mem = '0;
        tick_to(k + 5 + RD);
        rst = 1'b1;
        #1;
        chk("rst_in_wb_busy", {63'd0, busy}, 64'd0);
        tick_to(k + 7 + RD + WR);
        rst = 1'b0;
        n_fill = 0; n_wb = 0;
        fill(14'h0032, 64'h3232_3232_0000_0003, 1'b0, '0, '0);

        // Fill with writeback, then fill the written-back line.
        fill(14'h0040, 64'h4040_4040_0000_0004, 1'b1, 14'h0013, 64'hAAAA_5555_AAAA_5555);
        fill(14'h0013, 64'hAAAA_5555_AAAA_5555, 1'b0, '0, '0);

        // Back-to-back: req held through a fill + writeback; second fill is
        // the just-written victim and lands RD_LAT+1 edges after WB_WAIT exit.
        k = cyc;
        req = 1'b1; addr_mem = 14'h0041; wrt_bck = 1'b1;
        sb.push_back('{64'h4141_4141_0000_0005, k + 1 + RD});
        sb.push_back('{64'h2121_CAFE_2121_CAFE, k + 4 + 2*RD + WR});
        tick_to(k + 2 + RD);
        wrt_bck = 1'b0; addr_mem = 14'h0021; data_to_mem = 64'h2121_CAFE_2121_CAFE;
        tick_to(k + 3 + RD);
        data_to_mem = '0;
        tick_to(k + 4 + RD + WR);
        req = 1'b0;
        tick_to(k + 5 + 2*RD + WR);
        chk("b2b_busy_end", {63'd0, busy}, 64'd0);
        n_fill += 2; n_wb += 1;

        // Preload and req together: preload first, fill starts next edge;
        // a preload during busy is dropped.
        k = cyc;
        ld_en = 1'b1; ld_addr = 14'h0050; ld_data = 64'h5050_5050_C0DE_C0DE;
        req = 1'b1; addr_mem = 14'h0050;
        sb.push_back('{64'h5050_5050_C0DE_C0DE, k + 2 + RD});
        tick_to(k + 1);
        ld_en = 1'b0;
        tick_to(k + 2);
        req = 1'b0;
        ld_en = 1'b1; ld_addr = 14'h0051; ld_data = 64'hDEAD_DEAD_DEAD_DEAD;
        tick_to(k + 4);
        ld_en = 1'b0;
        tick_to(k + 3 + RD);
        chk("ld_req_busy_end", {63'd0, busy}, 64'd0);
        n_fill++;
        fill(14'h0051, 64'h5151_5151_0000_0006, 1'b0, '0, '0);

        // Aliasing: 0x400 maps onto line 0.
        fill(14'h0400, 64'h0F0F_0F0F_0000_0007, 1'b0, '0, '0);

`ifdef LINE_MEM_CTRL_STATS_EN
        chk("fill_cnt", {48'd0, fill_cnt}, 64'(n_fill));
        chk("wb_cnt", {48'd0, wb_cnt}, 64'(n_wb));
`endif

        tick_to(cyc + 4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_fills actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
